// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl_pkg: shared state encoding and access-size codes for the data-memory access controller
package dm_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} dm_state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
endpackage

// File: rtl/dm_store_align.sv
// dm_store_align: lane-replicates store data, builds byte strobes and flags misaligned or illegal sizes
module dm_store_align
  import dm_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        mis
);
  always_comb begin
    wstrb = size == SZ_B ? 4'b0001 << off : size == SZ_H ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    wdata = size == SZ_B ? {4{data[7:0]}} : size == SZ_H ? {2{data[15:0]}} : data;
    mis   = size == 2'd3 | (size == SZ_H & off[0]) | (size == SZ_W & off != 2'b00);
  end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences MEM-stage loads/stores over a req/ack data-memory port and stalls the pipeline
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [2:0]        MEM_funct3,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [31:0]       MEM_store_data,
  input  logic              ext_stall,
  input  logic              CSR_reset,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wstrb,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              dm_stall,
  output logic [31:0]       MEM_load_data,
  output logic              dm_misalign,
  output logic              dm_err
);
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  dm_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] wstrb;
  logic [31:0] wdata;
  logic mis, acc, issue, tmo, busy;
  dm_store_align u_align (
    .size (MEM_funct3[1:0]),
    .off  (MEM_addr[1:0]),
    .data (MEM_store_data),
    .wstrb(wstrb),
    .wdata(wdata),
    .mis  (mis)
  );
  always_comb begin
    acc         = MEM_MemRead | MEM_MemWrite;
    busy        = state == BUSY;
    issue       = state == IDLE & acc & !mis & !CSR_reset;
    tmo         = (TIMEOUT_CYC != 0) & cnt == LAST & !dm_ack;
    nxt         = state == IDLE ? (issue ? BUSY : IDLE)
                : busy ? (dm_ack ? (CSR_reset ? IDLE : DONE) : CSR_reset ? DRAIN : tmo ? DONE : BUSY)
                : state == DONE ? (ext_stall & !CSR_reset ? DONE : IDLE)
                : (dm_ack ? IDLE : DRAIN);
    dm_req      = busy | state == DRAIN;
    dm_stall    = issue | dm_req;
    dm_misalign = state == IDLE & acc & mis & !CSR_reset;
    dm_err      = busy & tmo & !CSR_reset;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wstrb      <= '0;
      dm_wdata      <= '0;
      MEM_load_data <= '0;
    end else begin
      state <= nxt;
      cnt   <= busy & nxt == BUSY ? cnt + 1'b1 : '0;
      if (issue) begin
        dm_we    <= MEM_MemWrite;
        dm_addr  <= {MEM_addr[ADDR_W-1:2], 2'b00};
        dm_wstrb <= MEM_MemWrite ? wstrb : 4'b0000;
        dm_wdata <= wdata;
      end
      // a flushed load never updates the data seen by MEM/WB
      if (busy & dm_ack & !CSR_reset & !dm_we) MEM_load_data <= dm_rdata;
      else if (dm_err) MEM_load_data <= '0;
    end
  end
endmodule
